// File: rtl/hack_cpu.sv
// hack_cpu -- single-cycle Hack CPU core (A, D and PC registers plus ALU).
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        synchronous active-low reset (A=D=PC=0, writeM forced low)
//   instruction  16-bit instruction word fetched from ROM at address pc
//   inM          16-bit data memory read value at addressM
//   stall        hold request (present only when CPU_STALL_EN is defined)
//   outM         ALU result / data to write to memory (combinational)
//   writeM       memory write strobe (combinational)
//   addressM     data memory address, A[14:0] (combinational, pre-edge A)
//   pc           instruction address, the PC register
//
// Configuration macro: CPU_STALL_EN adds the stall port. When it is not
// defined the core behaves exactly as if stall were tied low.

module hack_cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruction,
  input  logic [15:0] inM,
`ifdef CPU_STALL_EN
  input  logic        stall,
`endif
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc
);

  logic [15:0] a_reg, a_next;
  logic [15:0] d_reg, d_next;
  logic [14:0] pc_reg, pc_next;

  logic        hold;
  logic        is_c;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_y;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic        jump;

`ifdef CPU_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // Bits 14:13 of a C-instruction carry no meaning and are ignored.
  logic unused_bits;
  assign unused_bits = ^instruction[14:13];

  assign is_c     = instruction[15];
  // A-instructions run the ALU with all controls low; its result is unused.
  assign alu_ctrl = is_c ? instruction[11:6] : 6'b000000;
  assign alu_y    = instruction[12] ? inM : a_reg;

  hack_alu u_alu (
    .x   (d_reg),
    .y   (alu_y),
    .zx  (alu_ctrl[5]),
    .nx  (alu_ctrl[4]),
    .zy  (alu_ctrl[3]),
    .ny  (alu_ctrl[2]),
    .f   (alu_ctrl[1]),
    .no  (alu_ctrl[0]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // j1: out<0, j2: out==0, j3: out>0.
  assign jump = is_c & ((instruction[2] & alu_ng) |
                        (instruction[1] & alu_zr) |
                        (instruction[0] & ~alu_ng & ~alu_zr));

  always_comb begin
    a_next  = a_reg;
    d_next  = d_reg;
    pc_next = pc_reg + 15'd1;
    if (!is_c) begin
      a_next = instruction;
    end else begin
      if (instruction[5]) a_next = alu_out;
      if (instruction[4]) d_next = alu_out;
    end
    // Jump target is the A value before this edge, even if A is also written.
    if (jump) pc_next = a_reg[14:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg  <= 16'h0000;
      d_reg  <= 16'h0000;
      pc_reg <= 15'h0000;
    end else if (!hold) begin
      a_reg  <= a_next;
      d_reg  <= d_next;
      pc_reg <= pc_next;
    end
  end

  assign outM     = alu_out;
  assign writeM   = is_c & instruction[3] & rst_n & ~hold;
  assign addressM = a_reg[14:0];
  assign pc       = pc_reg;

endmodule

// hack_alu -- Hack ALU: optional zero/negate of each input, add or AND,
// optional negate of the result; zr and ng status flags.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] xz, xn, yz, yn, res;

  always_comb begin
    xz  = zx ? 16'h0000 : x;
    xn  = nx ? ~xz : xz;
    yz  = zy ? 16'h0000 : y;
    yn  = ny ? ~yz : yz;
    res = f ? (xn + yn) : (xn & yn);
    out = no ? ~res : res;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end

endmodule

// File: tb/tb_hack_cpu.sv
module tb_hack_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instruction;
  logic [15:0] inM;
`ifdef CPU_STALL_EN
  logic        stall;
`endif
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] ma, md;
  logic [14:0] mpc;

  hack_cpu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .inM         (inM),
`ifdef CPU_STALL_EN
    .stall       (stall),
`endif
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Apply inputs on the falling edge, settle, then let the test sample.
  task automatic drive(input logic [15:0] ins, input logic [15:0] m, input logic r);
    @(negedge clk);
    instruction = ins;
    inM         = m;
    rst_n       = r;
    #1;
    $display("txn ins=%h inM=%h rst_n=%0d pc=%h outM=%h writeM=%0d addressM=%h",
             ins, m, r, pc, outM, writeM, addressM);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(16'h0000, 16'h0000, 1'b0);
    tick();
    ma = 16'h0; md = 16'h0; mpc = 15'h0;
  endtask

  // Hack comp table expressed as arithmetic on the selected operands.
  function automatic logic [15:0] ref_comp(input logic [5:0] c, input logic [15:0] x,
                                           input logic [15:0] y);
    case (c)
      6'b101010: ref_comp = 16'd0;
      6'b111111: ref_comp = 16'd1;
      6'b111010: ref_comp = -16'd1;
      6'b001100: ref_comp = x;
      6'b110000: ref_comp = y;
      6'b001101: ref_comp = ~x;
      6'b110001: ref_comp = ~y;
      6'b001111: ref_comp = -x;
      6'b110011: ref_comp = -y;
      6'b011111: ref_comp = x + 16'd1;
      6'b110111: ref_comp = y + 16'd1;
      6'b001110: ref_comp = x - 16'd1;
      6'b110010: ref_comp = y - 16'd1;
      6'b000010: ref_comp = x + y;
      6'b010011: ref_comp = x - y;
      6'b000111: ref_comp = y - x;
      6'b000000: ref_comp = x & y;
      6'b010101: ref_comp = x | y;
      default:   ref_comp = 16'hxxxx;
    endcase
  endfunction

  // Executes one instruction on the model: returns the expected
  // combinational outputs and advances the model state.
  task automatic ref_exec(input logic [15:0] ins, input logic [15:0] m,
                          output logic [15:0] o, output logic wr);
    logic [15:0] y;
    logic        jmp;
    logic [15:0] old_a;
    old_a = ma;
    if (ins[15] == 1'b0) begin
      o   = 16'h0;
      wr  = 1'b0;
      ma  = ins;
      mpc = mpc + 15'd1;
    end else begin
      y   = ins[12] ? m : ma;
      o   = ref_comp(ins[11:6], md, y);
      wr  = ins[3];
      jmp = (ins[2] && $signed(o) < 0) || (ins[1] && o == 0) || (ins[0] && $signed(o) > 0);
      if (ins[5]) ma = o;
      if (ins[4]) md = o;
      mpc = jmp ? old_a[14:0] : mpc + 15'd1;
    end
  endtask

  task automatic test_reset();
    drive(16'hFFFF, 16'h1234, 1'b0);
    checks++;
    if (writeM !== 1'b0) begin
      failures++; $display("FAIL reset_writeM_initial got=%b exp=0", writeM);
    end
    tick();
    // Build up nonzero state, then reset mid-program with a garbage AMD;JMP word.
    drive(16'h1234, 16'h0, 1'b1); tick();
    drive(16'hEC10, 16'h0, 1'b1); tick();
    drive(16'h0777, 16'h0, 1'b1); tick();
    drive(16'hFFFF, 16'h5555, 1'b0);
    checks++;
    if (writeM !== 1'b0) begin
      failures++; $display("FAIL reset_writeM got=%b exp=0", writeM);
    end
    tick();
    checks++;
    if (pc !== 15'h0) begin
      failures++; $display("FAIL reset_pc got=%h exp=0000", pc);
    end
    drive(16'hE300, 16'h0, 1'b1);  // D, no dest: observe D on outM
    checks++;
    if (addressM !== 15'h0) begin
      failures++; $display("FAIL reset_A got=%h exp=0000", addressM);
    end
    checks++;
    if (outM !== 16'h0) begin
      failures++; $display("FAIL reset_D got=%h exp=0000", outM);
    end
    checks++;
    if (pc !== 15'h0) begin
      failures++; $display("FAIL reset_restart_pc got=%h exp=0000", pc);
    end
    tick();
    drive(16'hEC00, 16'h0, 1'b1);  // A, no dest: observe full A on outM
    checks++;
    if (outM !== 16'h0) begin
      failures++; $display("FAIL reset_A_full got=%h exp=0000", outM);
    end
    checks++;
    if (pc !== 15'h1) begin
      failures++; $display("FAIL reset_pc_step got=%h exp=0001", pc);
    end
    tick();
  endtask

  task automatic test_add_store();
    logic [15:0] prog [6];
    prog = '{16'h0011, 16'hEC10, 16'h0003, 16'hE090, 16'h0000, 16'hE308};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(prog[k], 16'h0, 1'b1);
      checks++;
      if (pc !== 15'(k)) begin
        failures++; $display("FAIL add_pc got=%h exp=%h", pc, 15'(k));
      end
      if (k == 5) begin
        checks++;
        if (outM !== 16'd20) begin
          failures++; $display("FAIL add_outM got=%0d exp=20", outM);
        end
        checks++;
        if (addressM !== 15'h0 || writeM !== 1'b1) begin
          failures++; $display("FAIL add_store got addr=%h wr=%b exp addr=0000 wr=1", addressM, writeM);
        end
      end
      tick();
    end
  endtask

  task automatic test_jump();
    do_reset();
    drive(16'h0011, 16'h0, 1'b1); tick();
    drive(16'hEC10, 16'h0, 1'b1); tick();
    drive(16'h0003, 16'h0, 1'b1); tick();
    drive(16'hE4D0, 16'h0, 1'b1);  // D=D-A
    checks++;
    if (outM !== 16'd14) begin
      failures++; $display("FAIL jump_dminusa got=%0d exp=14", outM);
    end
    tick();
    drive(16'h0064, 16'h0, 1'b1); tick();
    drive(16'hE301, 16'h0, 1'b1);  // D;JGT
    checks++;
    if (writeM !== 1'b0) begin
      failures++; $display("FAIL jump_jgt_writeM got=%b exp=0", writeM);
    end
    tick();
    checks++;
    if (pc !== 15'd100) begin
      failures++; $display("FAIL jump_jgt_pc got=%0d exp=100", pc);
    end
    drive(16'h0000, 16'h0, 1'b1); tick();
    drive(16'hEC10, 16'h0, 1'b1); tick();  // D=0
    drive(16'hE305, 16'h0, 1'b1);          // D;JNE, not taken
    tick();
    checks++;
    if (pc !== 15'd103) begin
      failures++; $display("FAIL jump_jne_pc got=%0d exp=103", pc);
    end
  endtask

  task automatic test_am_inc();
    do_reset();
    drive(16'h000A, 16'h0, 1'b1); tick();
    drive(16'hFDE8, 16'd5, 1'b1);  // AM=M+1
    checks++;
    if (outM !== 16'd6 || addressM !== 15'd10 || writeM !== 1'b1) begin
      failures++; $display("FAIL aminc got out=%0d addr=%0d wr=%b exp out=6 addr=10 wr=1",
                           outM, addressM, writeM);
    end
    tick();
    drive(16'hE300, 16'h0, 1'b1);
    checks++;
    if (addressM !== 15'd6) begin
      failures++; $display("FAIL aminc_A got=%0d exp=6", addressM);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(16'h7FFF, 16'h0, 1'b1); tick();
    drive(16'hEA87, 16'h0, 1'b1); tick();  // 0;JMP
    checks++;
    if (pc !== 15'h7FFF) begin
      failures++; $display("FAIL wrap_jmp got=%h exp=7fff", pc);
    end
    drive(16'hE300, 16'h0, 1'b1); tick();
    checks++;
    if (pc !== 15'h0000) begin
      failures++; $display("FAIL wrap_pc got=%h exp=0000", pc);
    end
  endtask

`ifdef CPU_STALL_EN
  task automatic test_stall();
    do_reset();
    drive(16'h0009, 16'h0, 1'b1); tick();
    drive(16'hEC10, 16'h0, 1'b1); tick();  // D=9
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(16'hE308, 16'h0, 1'b1);
      checks++;
      if (writeM !== 1'b0 || pc !== 15'd2 || addressM !== 15'd9 || outM !== 16'd9) begin
        failures++; $display("FAIL stall_hold got wr=%b pc=%0d addr=%0d out=%0d exp wr=0 pc=2 addr=9 out=9",
                             writeM, pc, addressM, outM);
      end
      tick();
    end
    stall = 1'b0;
    drive(16'hE308, 16'h0, 1'b1);
    checks++;
    if (writeM !== 1'b1 || pc !== 15'd2) begin
      failures++; $display("FAIL stall_release got wr=%b pc=%0d exp wr=1 pc=2", writeM, pc);
    end
    tick();
    drive(16'hE300, 16'h0, 1'b1);
    checks++;
    if (writeM !== 1'b0 || pc !== 15'd3) begin
      failures++; $display("FAIL stall_after got wr=%b pc=%0d exp wr=0 pc=3", writeM, pc);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [5:0]  codes [18];
    logic [15:0] ins, m, exp_o;
    logic [14:0] exp_pc, exp_addr;
    logic        exp_wr;
    codes = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
              6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
              6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      m = 16'($urandom);
      if ($urandom_range(9) < 4)
        ins = {1'b0, 15'($urandom)};
      else
        ins = {1'b1, 2'($urandom), 1'($urandom), codes[$urandom_range(17)], 6'($urandom)};
      drive(ins, m, 1'b1);
      exp_pc   = mpc;
      exp_addr = ma[14:0];
      ref_exec(ins, m, exp_o, exp_wr);
      checks++;
      if (pc !== exp_pc || addressM !== exp_addr || writeM !== exp_wr) begin
        failures++; $display("FAIL rand_ctl n=%0d ins=%h got pc=%h addr=%h wr=%b exp pc=%h addr=%h wr=%b",
                             n, ins, pc, addressM, writeM, exp_pc, exp_addr, exp_wr);
      end
      if (ins[15]) begin
        checks++;
        if (outM !== exp_o) begin
          failures++; $display("FAIL rand_outM n=%0d ins=%h got=%h exp=%h", n, ins, outM, exp_o);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instruction = 16'h0;
    inM         = 16'h0;
`ifdef CPU_STALL_EN
    stall       = 1'b0;
`endif
    test_reset();
    test_add_store();
    test_jump();
    test_am_inc();
    test_wrap();
`ifdef CPU_STALL_EN
    test_stall();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
